piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Upstream stage for the 4-bit SIPO shift register: converts parallel words into the serial bit stream that drives the SIPO's serial input.
- Accepts words over a valid/ready handshake.
- Shifts each word out LSB-first, one bit per clock, so the downstream SIPO holds the original word on its parallel output exactly WIDTH clocks after the first bit.
- Pulses word_done in the cycle the downstream SIPO's parallel output holds the complete word.

Parameters:
- WIDTH, 4: data word width in bits; must be >= 2.
- GAP_CYCLES, 0: idle cycles inserted between consecutive words; 0 allows back-to-back words.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  input  1  in_data is valid.
- in_data  input  WIDTH  parallel word to serialize.
- in_ready  output  1  block can accept a word this cycle.
- s_out  output  1  serial data, registered; connects to the SIPO serial input.
- s_active  output  1  s_out carries a data (or parity) bit this cycle.
- word_done  output  1  single-cycle pulse: last bit was sampled downstream on the previous edge.

Behaviour:
- Reset (async assert, sync release), all outputs and state:
  - state = IDLE
  - s_out = 0, s_active = 0, word_done = 0
  - shift register = 0, bit counter = 0, gap counter = 0
  - in_ready = 1 (combinational from state).
- States:
  - IDLE: in_ready = 1, s_out = 0, s_active = 0.
    - On accept (in_valid & in_ready at posedge): s_out <= in_data[0], shreg <= in_data >> 1, bitcnt <= 0, s_active <= 1; go to SHIFT.
  - SHIFT: one bit per cycle.
    - Each edge: s_out <= shreg[0], shreg <= shreg >> 1, bitcnt++.
    - bit k of the accepted word is on s_out during the k-th cycle after the accept edge (k = 0..WIDTH-1).
    - Final bit (bitcnt == WIDTH-1) at the next edge:
      - word_done <= 1 (pulse for exactly one cycle).
      - If GAP_CYCLES > 0: go to GAP; s_out <= 0, s_active <= 0.
      - Else if a word is accepted on this same edge: load it as in IDLE and stay in SHIFT (no bubble).
      - Else: go to IDLE.
  - GAP: s_out = 0, s_active = 0, in_ready = 0. Count GAP_CYCLES cycles, then go to IDLE.
- in_ready:
  - 1 in IDLE.
  - 1 in the final SHIFT cycle only when GAP_CYCLES == 0.
  - 0 otherwise.
- in_data is sampled only on the accept edge; later changes are ignored.
- in_valid while in_ready = 0: no effect; the word is held by the producer (standard valid/ready, no drop).
- Reset mid-word: the word is abandoned; no word_done; s_out is forced to 0 immediately.
- Counters sized $clog2(WIDTH) and $clog2(GAP_CYCLES+1); no wrap beyond terminal value.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After bit WIDTH-1, one extra cycle drives the even-parity bit (XOR of the accepted word) on s_out with s_active = 1 (state PARITY).
  - word_done pulses one cycle after the parity bit.
  - Back-to-back ready moves to the parity cycle.
- Undefined: no PARITY state and no extra cycle; timing as above.

Decomposition:
- Shared package piso_pkg:
  - State enum (IDLE, SHIFT, GAP, PARITY).
  - Default WIDTH constant.
  - Function for even parity.
- One natural sub-module, piso_bit_counter: parameterized up-counter with load/enable and a terminal-count flag, instanced for both the bit counter and the gap counter.

Test Plan:
- Single word, WIDTH = 4, in_data = 4'b1011 accepted at edge 0 -> s_out = 1, 1, 0, 1 in cycles 1-4; word_done = 1 in cycle 5 only; SIPO model p_out = 4'b1011 in cycle 5.
- Back-to-back, GAP_CYCLES = 0, words 4'hA then 4'h5 with in_valid held -> continuous bits 0,1,0,1,1,0,1,0; in_ready high in the final bit cycle; two word_done pulses 4 cycles apart.
- GAP_CYCLES = 2 -> after the last bit, s_out = 0 and in_ready = 0 for 2 cycles, then in_ready = 1.
- Backpressure: in_valid = 1 with 4'hF during SHIFT -> not accepted until in_ready = 1; the word is then serialized intact.
- Async reset asserted mid-SHIFT between edges -> s_out, s_active, word_done = 0 immediately; no word_done after release; in_ready = 1.
- PISO_PARITY_EN, in_data = 4'b0111 -> 5 active bits 1,1,1,0,1 (parity 1); word_done in cycle 6.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer:
// FSM state encoding, default word width, the even-parity helper and a
// counter-width helper used to size the bit and gap counters.
package piso_pkg;

    // Serializer FSM states. PARITY is only reachable when PISO_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        GAP    = 2'd2,
        PARITY = 2'd3
    } state_e;

    // Default data word width (matches the downstream 4-bit SIPO).
    localparam int DEFAULT_WIDTH = 4;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PARITY_MAX_W = 64;

    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

    // Bits needed to hold 0..max_value, never less than one.
    function automatic int cnt_width(input int max_value);
        int w;
        w = $clog2(max_value + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// Saturating up-counter with synchronous load-to-zero, count enable and a
// terminal-count flag. Used for both the bit position and the gap length.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int CNT_W    = 2,
    parameter int TERMINAL = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TERM_VAL);

    // Next count: load wins over enable; hold at the terminal value (no wrap).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : piso_bit_counter

// File: rtl/piso_serializer.sv
// Parallel-to-serial front end for the 4-bit SIPO shift register.
// Words arrive on a valid/ready handshake and leave LSB-first, one bit per
// clock, on a registered serial output. word_done pulses in the cycle the
// downstream SIPO holds the whole word.
// Optional build macro: PISO_PARITY_EN appends an even-parity bit after
// each word (extra PARITY cycle); undefined means no parity cycle.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             s_out,
    output logic             s_active,
    output logic             word_done
);

    localparam int   BIT_W    = cnt_width(WIDTH - 1);
    localparam int   GAP_W    = cnt_width(GAP_CYCLES);
    localparam int   GAP_TERM = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam logic GAP_EN   = (GAP_CYCLES > 0);

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic             s_out_q,     s_out_d;
    logic             s_active_q,  s_active_d;
    logic             word_done_q, word_done_d;
`ifdef PISO_PARITY_EN
    logic             parity_q,    parity_d;
`endif

    logic accept;
    logic do_load;
    logic finish;
    logic bit_load;
    logic bit_en;
    logic bit_tc;
    logic gap_load;
    logic gap_en;
    logic gap_tc;

    // Position of the bit currently on s_out within the word (0..WIDTH-1).
    piso_bit_counter #(
        .CNT_W    (BIT_W),
        .TERMINAL (WIDTH - 1)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (bit_load),
        .en_i   (bit_en),
        .tc_o   (bit_tc)
    );

    // Idle cycles spent between words.
    piso_bit_counter #(
        .CNT_W    (GAP_W),
        .TERMINAL (GAP_TERM)
    ) u_gap_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (gap_load),
        .en_i   (gap_en),
        .tc_o   (gap_tc)
    );

    // Ready decode: idle, or the last serial cycle of a word when words may
    // run back-to-back (the last serial cycle is the parity cycle if enabled).
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
`ifdef PISO_PARITY_EN
            SHIFT:   in_ready = 1'b0;
            PARITY:  in_ready = !GAP_EN;
`else
            SHIFT:   in_ready = !GAP_EN && bit_tc;
            PARITY:  in_ready = 1'b0;
`endif
            GAP:     in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Next-state and registered-output decode. The state case only raises
    // finish/do_load; the shared word-end and word-load actions follow it.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        s_out_d     = 1'b0;
        s_active_d  = 1'b0;
        word_done_d = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d    = parity_q;
`endif
        do_load     = 1'b0;
        finish      = 1'b0;
        bit_load    = 1'b0;
        bit_en      = 1'b0;
        gap_load    = 1'b0;
        gap_en      = 1'b0;

        case (state_q)
            IDLE: begin
                do_load = accept;
            end
            SHIFT: begin
                bit_en = 1'b1;
                if (!bit_tc) begin
                    s_out_d    = shreg_q[0];
                    shreg_d    = shreg_q >> 1;
                    s_active_d = 1'b1;
                end else begin
`ifdef PISO_PARITY_EN
                    state_d    = PARITY;
                    s_out_d    = parity_q;
                    s_active_d = 1'b1;
`else
                    finish     = 1'b1;
`endif
                end
            end
            PARITY: begin
                finish = 1'b1;
            end
            GAP: begin
                gap_en = 1'b1;
                if (gap_tc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Last serial bit has just been sampled downstream: announce it and
        // either rest for the gap, chain the next word, or go idle.
        if (finish) begin
            word_done_d = 1'b1;
            if (GAP_EN) begin
                state_d  = GAP;
                gap_load = 1'b1;
            end else if (accept) begin
                do_load = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        // Capture a new word: bit 0 goes straight to s_out, the rest waits.
        if (do_load) begin
            state_d    = SHIFT;
            s_out_d    = in_data[0];
            shreg_d    = in_data >> 1;
            s_active_d = 1'b1;
            bit_load   = 1'b1;
`ifdef PISO_PARITY_EN
            parity_d   = even_parity(PARITY_MAX_W'(in_data));
`endif
        end
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            s_out_q     <= 1'b0;
            s_active_q  <= 1'b0;
            word_done_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            s_out_q     <= s_out_d;
            s_active_q  <= s_active_d;
            word_done_q <= word_done_d;
`ifdef PISO_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign s_out     = s_out_q;
    assign s_active  = s_active_q;
    assign word_done = word_done_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer. Two instances: dut0 with
// no inter-word gap and dutg with GAP_CYCLES = 2. A 4-bit SIPO model fed by
// dut0's serial output checks the reassembled word.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       vld0 = 1'b0;
    logic [3:0] dat0 = 4'h0;
    logic       rdy0, sout0, sact0, done0;

    logic       vldg = 1'b0;
    logic [3:0] datg = 4'h0;
    logic       rdyg, soutg, sactg, doneg;

    logic [3:0] sipo = 4'h0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .GAP_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld0),
        .in_data   (dat0),
        .in_ready  (rdy0),
        .s_out     (sout0),
        .s_active  (sact0),
        .word_done (done0)
    );

    piso_serializer #(.WIDTH(4), .GAP_CYCLES(2)) dutg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vldg),
        .in_data   (datg),
        .in_ready  (rdyg),
        .s_out     (soutg),
        .s_active  (sactg),
        .word_done (doneg)
    );

    // Downstream SIPO model: serial bit enters the MSB, so after four
    // LSB-first bits it holds the original word.
    always @(posedge clk) begin
        sipo <= {sout0, sipo[3:1]};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (sout0 !== 1'b0) begin n_err++; $display("FAIL reset_s_out got=%b exp=0", sout0); end
        n_cmp++; if (sact0 !== 1'b0) begin n_err++; $display("FAIL reset_s_active got=%b exp=0", sact0); end
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_word_done got=%b exp=0", done0); end
        n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", rdy0); end
        n_cmp++; if (rdyg !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_gap got=%b exp=1", rdyg); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        $display("reset released");
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity;
        logic [4:0] bits;
        bits = 5'b10111; // cycle1..5: 1,1,1,0,1 (parity of 0111 = 1)
        dat0 = 4'b0111; vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            n_cmp++; if (sout0 !== bits[c-1]) begin n_err++; $display("FAIL parity_bit c=%0d got=%b exp=%b", c, sout0, bits[c-1]); end
            n_cmp++; if (sact0 !== 1'b1) begin n_err++; $display("FAIL parity_active c=%0d got=%b exp=1", c, sact0); end
            n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL parity_done_early c=%0d got=%b exp=0", c, done0); end
            n_cmp++; if (rdy0 !== (c == 5)) begin n_err++; $display("FAIL parity_ready c=%0d got=%b exp=%b", c, rdy0, (c == 5)); end
            tick();
        end
        n_cmp++; if (done0 !== 1'b1) begin n_err++; $display("FAIL parity_done got=%b exp=1", done0); end
        n_cmp++; if (sact0 !== 1'b0) begin n_err++; $display("FAIL parity_idle_active got=%b exp=0", sact0); end
        tick();
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL parity_done_pulse got=%b exp=0", done0); end
        $display("word 0x7 serialized with parity");
    endtask
`else
    task automatic test_single_word;
        logic [3:0] bits;
        bits = 4'b1011;
        dat0 = 4'b1011; vld0 = 1'b1;
        tick(); // accept edge 0
        vld0 = 1'b0;
        dat0 = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            n_cmp++; if (sout0 !== bits[c-1]) begin n_err++; $display("FAIL single_bit c=%0d got=%b exp=%b", c, sout0, bits[c-1]); end
            n_cmp++; if (sact0 !== 1'b1) begin n_err++; $display("FAIL single_active c=%0d got=%b exp=1", c, sact0); end
            n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL single_done_early c=%0d got=%b exp=0", c, done0); end
            n_cmp++; if (rdy0 !== (c == 4)) begin n_err++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, rdy0, (c == 4)); end
            tick();
        end
        n_cmp++; if (done0 !== 1'b1) begin n_err++; $display("FAIL single_done got=%b exp=1", done0); end
        n_cmp++; if (sipo !== 4'b1011) begin n_err++; $display("FAIL single_sipo got=%h exp=b", sipo); end
        n_cmp++; if (sact0 !== 1'b0) begin n_err++; $display("FAIL single_idle_active got=%b exp=0", sact0); end
        n_cmp++; if (sout0 !== 1'b0) begin n_err++; $display("FAIL single_idle_s_out got=%b exp=0", sout0); end
        n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL single_idle_ready got=%b exp=1", rdy0); end
        tick();
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL single_done_pulse got=%b exp=0", done0); end
        $display("word 0xb serialized, sipo=%h", sipo);
    endtask

    // Two words with in_valid held throughout; second word is accepted on
    // the final bit edge of the first. Reused for the backpressure case.
    task automatic run_pair(input string name, input logic [3:0] w0, input logic [3:0] w1);
        logic [7:0] bits;
        bits = {w1, w0};
        dat0 = w0; vld0 = 1'b1;
        tick(); // edge 0
        dat0 = w1;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
                n_cmp++; if (sout0 !== bits[c-1]) begin n_err++; $display("FAIL %s_bit c=%0d got=%b exp=%b", name, c, sout0, bits[c-1]); end
                n_cmp++; if (sact0 !== 1'b1) begin n_err++; $display("FAIL %s_active c=%0d got=%b exp=1", name, c, sact0); end
            end
            n_cmp++; if (done0 !== (c == 5 || c == 9)) begin n_err++; $display("FAIL %s_done c=%0d got=%b exp=%b", name, c, done0, (c == 5 || c == 9)); end
            if (c <= 4) begin
                n_cmp++; if (rdy0 !== (c == 4)) begin n_err++; $display("FAIL %s_ready c=%0d got=%b exp=%b", name, c, rdy0, (c == 4)); end
            end
            if (c == 5) begin
                n_cmp++; if (sipo !== w0) begin n_err++; $display("FAIL %s_sipo0 got=%h exp=%h", name, sipo, w0); end
            end
            if (c == 9) begin
                n_cmp++; if (sipo !== w1) begin n_err++; $display("FAIL %s_sipo1 got=%h exp=%h", name, sipo, w1); end
                n_cmp++; if (sact0 !== 1'b0) begin n_err++; $display("FAIL %s_idle_active got=%b exp=0", name, sact0); end
            end
            tick();
            if (c == 4) begin
                // second word taken on this edge; later data changes must be ignored
                vld0 = 1'b0;
                dat0 = ~w1;
            end
        end
        $display("%s: words 0x%h 0x%h serialized", name, w0, w1);
    endtask

    task automatic test_back_to_back;
        run_pair("b2b", 4'hA, 4'h5);
    endtask

    task automatic test_backpressure;
        run_pair("bp", 4'h3, 4'hF);
    endtask

    task automatic test_gap;
        logic [3:0] bits;
        bits = 4'b0110;
        datg = 4'b0110; vldg = 1'b1;
        tick(); // edge 0
        datg = 4'h9; // held during the word and the gap
        for (int c = 1; c <= 8; c++) begin
            if (c <= 4) begin
                n_cmp++; if (soutg !== bits[c-1]) begin n_err++; $display("FAIL gap_bit c=%0d got=%b exp=%b", c, soutg, bits[c-1]); end
                n_cmp++; if (rdyg !== 1'b0) begin n_err++; $display("FAIL gap_ready_shift c=%0d got=%b exp=0", c, rdyg); end
            end
            if (c == 5 || c == 6) begin
                n_cmp++; if (soutg !== 1'b0) begin n_err++; $display("FAIL gap_s_out c=%0d got=%b exp=0", c, soutg); end
                n_cmp++; if (sactg !== 1'b0) begin n_err++; $display("FAIL gap_active c=%0d got=%b exp=0", c, sactg); end
                n_cmp++; if (rdyg !== 1'b0) begin n_err++; $display("FAIL gap_ready c=%0d got=%b exp=0", c, rdyg); end
            end
            n_cmp++; if (doneg !== (c == 5)) begin n_err++; $display("FAIL gap_done c=%0d got=%b exp=%b", c, doneg, (c == 5)); end
            if (c == 7) begin
                n_cmp++; if (rdyg !== 1'b1) begin n_err++; $display("FAIL gap_ready_after got=%b exp=1", rdyg); end
            end
            if (c == 8) begin
                n_cmp++; if (soutg !== 1'b1 || sactg !== 1'b1) begin n_err++; $display("FAIL gap_next_word got=%b/%b exp=1/1", soutg, sactg); end
            end
            tick();
            if (c == 7) vldg = 1'b0;
        end
        repeat (8) tick();
        $display("gap: words 0x6 0x9 serialized with 2-cycle gap");
    endtask

    task automatic test_reset_mid_word;
        dat0 = 4'b1011; vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        tick(); // cycle 2, mid-word
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (sout0 !== 1'b0) begin n_err++; $display("FAIL rstmid_s_out got=%b exp=0", sout0); end
        n_cmp++; if (sact0 !== 1'b0) begin n_err++; $display("FAIL rstmid_active got=%b exp=0", sact0); end
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b exp=0", done0); end
        n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", rdy0); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++; if (done0 !== 1'b0 || sact0 !== 1'b0) begin n_err++; $display("FAIL rstmid_after c=%0d got=%b/%b exp=0/0", c, done0, sact0); end
        end
        n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready_after got=%b exp=1", rdy0); end
        $display("reset mid-word: word abandoned");
    endtask
`endif

    initial begin
        test_reset();
`ifdef PISO_PARITY_EN
        test_parity();
`else
        test_single_word();
        tick();
        test_back_to_back();
        tick();
        test_backpressure();
        tick();
        test_gap();
        test_reset_mid_word();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_piso_serializer
